// File: rtl/link_frame_ctrl.sv
// Frame sequencer: fetches each word from a TX BRAM, loads the serializer, deserializes the link bit stream and stores it into an RX BRAM.
// Optional build macro LINK_FRAME_LOOP_EN: frames repeat back to back until abort.
module link_frame_ctrl #(
  parameter int N     = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] tx_addr,
  output logic          tx_load,
  input  logic          serial_in,
  output logic [AW-1:0] rx_addr,
  output logic [N-1:0]  rx_data,
  output logic          rx_we,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] STORE = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [CW-1:0] bit_reg, bit_next;
  logic [N-1:0]  rx_data_reg, rx_data_next;
  logic [15:0]   frame_cnt_reg, frame_cnt_next;
  logic [N-1:0]  shift_word;
  logic          store_ok;
  logic          last_word;

  // New bits enter at the MSB so the first (LSB-first) bit ends at bit 0.
  generate
    if (N == 1) begin : g_shift_1
      assign shift_word = serial_in;
    end else begin : g_shift_n
      assign shift_word = {serial_in, rx_data_reg[N-1:1]};
    end
  endgenerate

  // A store is cancelled by abort in the same cycle, so the partial frame never commits.
  assign store_ok  = (state_reg == STORE) && !abort;
  assign last_word = (idx_reg == LAST_IDX);

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    bit_next       = bit_reg;
    rx_data_next   = rx_data_reg;
    frame_cnt_next = frame_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        bit_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        rx_data_next = shift_word;
        bit_next     = bit_reg + CW'(1);
        if (bit_reg == LAST_BIT) begin
          state_next = STORE;
        end
      end
      STORE: begin
        if (last_word) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
`ifdef LINK_FRAME_LOOP_EN
          idx_next   = '0;
          state_next = FETCH;
`else
          state_next = IDLE;
`endif
        end else begin
          idx_next   = idx_reg + AW'(1);
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over every transition, including start in IDLE.
    if (abort) begin
      state_next     = IDLE;
      idx_next       = idx_reg;
      bit_next       = bit_reg;
      rx_data_next   = rx_data_reg;
      frame_cnt_next = frame_cnt_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      bit_reg       <= '0;
      rx_data_reg   <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      bit_reg       <= bit_next;
      rx_data_reg   <= rx_data_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign tx_addr   = idx_reg;
  assign rx_addr   = idx_reg;
  assign tx_load   = (state_reg == LOAD);
  assign rx_we     = store_ok;
  assign done      = store_ok && last_word;
  assign busy      = (state_reg != IDLE);
  assign rx_data   = rx_data_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_link_frame_ctrl.sv
// Bench for link_frame_ctrl: TX BRAM + loopback serializer environment, cycle-level expectations derived from the word timing rules.
module tb_link_frame_ctrl;
  localparam int N     = 8;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int W     = N + 3;
  localparam int FLEN  = DEPTH * W;

  logic          clk = 1'b0;
  logic          rst, start, abort, serial_in;
  logic [AW-1:0] tx_addr, rx_addr;
  logic          tx_load, rx_we, busy, done;
  logic [N-1:0]  rx_data;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  logic [N-1:0] tx_mem [2**AW];
  logic [N-1:0] tx_rd, ser;
  int           wr_cnt [DEPTH];

  always #5 clk = ~clk;

  link_frame_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tx_addr(tx_addr), .tx_load(tx_load), .serial_in(serial_in),
    .rx_addr(rx_addr), .rx_data(rx_data), .rx_we(rx_we),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  // Environment: synchronous-read TX BRAM, LSB-first serializer looped back, RX write counter.
  assign serial_in = ser[0];
  always @(posedge clk) begin
    tx_rd <= tx_mem[tx_addr];
    ser   <= tx_load ? tx_rd : (ser >> 1);
    if (rx_we && (int'(rx_addr) < DEPTH)) wr_cnt[rx_addr] <= wr_cnt[rx_addr] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_we"}, 32'(rx_we), 0);
    chk({tag, "_load"}, 32'(tx_load), 0);
    chk({tag, "_fc"}, 32'(frame_cnt), 0);
    chk({tag, "_txa"}, 32'(tx_addr), 0);
    chk({tag, "_rxa"}, 32'(rx_addr), 0);
    chk({tag, "_rxd"}, 32'(rx_data), 0);
  endtask

  // One frame from a start pulse; abort_c = cycle (1 = FETCH of word 0) carrying abort, 0 = none.
  task automatic run_frame(input int abort_c, input bit rand_start, input string tag);
    int snap [DEPTH];
    int expw [DEPTH];
    int end_c, eff;
    bit live, e_we, e_done;
    int phase, word;
    for (int w = 0; w < DEPTH; w++) begin
      snap[w] = wr_cnt[w];
      expw[w] = 0;
    end
    eff = abort_c;
`ifdef LINK_FRAME_LOOP_EN
    if (eff == 0) eff = FLEN + 1;
    end_c = eff;
`else
    end_c = (eff != 0 && eff <= FLEN) ? eff : FLEN;
`endif
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    for (int c = 1; c <= end_c + 3; c++) begin
      @(negedge clk);
      live  = (c <= end_c);
      phase = (c - 1) % W;
      word  = ((c - 1) / W) % DEPTH;
      abort = (c == eff);
      start = (live && rand_start) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      e_we   = live && (phase == W - 1) && (c != eff);
      e_done = e_we && (word == DEPTH - 1);
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(live));
      chk($sformatf("%s_load_c%0d", tag, c), 32'(tx_load), 32'(live && phase == 1));
      chk($sformatf("%s_we_c%0d", tag, c), 32'(rx_we), 32'(e_we));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(e_done));
      chk($sformatf("%s_fc_c%0d", tag, c), 32'(frame_cnt), 32'(exp_fc & 16'hFFFF));
      if (live) chk($sformatf("%s_txa_c%0d", tag, c), 32'(tx_addr), 32'(word));
      if (e_we) begin
        chk($sformatf("%s_rxa_c%0d", tag, c), 32'(rx_addr), 32'(word));
        chk($sformatf("%s_rxd_c%0d", tag, c), 32'(rx_data), 32'(tx_mem[word]));
        expw[word]++;
      end
      if (e_done) exp_fc++;
    end
    start = 1'b0;
    abort = 1'b0;
    for (int w = 0; w < DEPTH; w++)
      chk($sformatf("%s_writes_w%0d", tag, w), 32'(wr_cnt[w] - snap[w]), 32'(expw[w]));
  endtask

  initial begin
    int s4, s5;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int a = 0; a < 2**AW; a++) tx_mem[a] = (a < DEPTH) ? N'(a) : '0;
    #1;
    chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;

    // Counting pattern 0x00..0x09, done at cycle 110, frame_cnt 1.
    run_frame(0, 1'b0, "count");
    chk("count_fc_end", 32'(frame_cnt), 32'(exp_fc));

    // 0xA5 at address 0, random payload, start re-pulsed while busy.
    for (int a = 0; a < DEPTH; a++) tx_mem[a] = N'($urandom);
    tx_mem[0] = 8'hA5;
    run_frame(0, 1'b1, "rand");

    // Abort in the 4th SHIFT cycle of word 3.
    run_frame(3 * W + 6, 1'b0, "abort3");

    // Abort at a random cycle.
    for (int a = 0; a < DEPTH; a++) tx_mem[a] = N'($urandom);
    run_frame(int'($urandom_range(1, FLEN)), 1'b1, "abortr");

    // start and abort together in IDLE stay in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("sa_busy0", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("sa_busy1", 32'(busy), 0);
    chk("sa_load1", 32'(tx_load), 0);

    // Reset pulse during STORE of word 5.
    s4 = wr_cnt[4];
    s5 = wr_cnt[5];
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 6 * W; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("rst5_in_store", 32'(rx_we), 1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("rst5");
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_busy%0d", k), 32'(busy), 0);
      chk($sformatf("post_rst_we%0d", k), 32'(rx_we), 0);
      chk($sformatf("post_rst_done%0d", k), 32'(done), 0);
    end
    chk("rst5_w4_written", 32'(wr_cnt[4] - s4), 1);
    chk("rst5_w5_unwritten", 32'(wr_cnt[5] - s5), 0);

    // Restart after reset rewrites from address 0.
    run_frame(0, 1'b0, "rerun");

`ifdef LINK_FRAME_LOOP_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
    run_frame(3 * FLEN + 2, 1'b0, "loop3");
    chk("loop3_fc", 32'(frame_cnt), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_frame_ctrl.md
LINK_FRAME_CTRL -- requirements
Module: link_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: link word width in bits.
REQ-002 SHALL have parameter DEPTH, default 10: number of words per frame (2..2^AW).
REQ-003 SHALL have parameter AW, default 4: BRAM address width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a frame.
REQ-007 SHALL have port abort  in  1  terminate the current frame.
REQ-008 SHALL have port tx_addr  out  AW  read address to the TX BRAM (1-cycle synchronous read).
REQ-009 SHALL have port tx_load  out  1  load strobe to the serializer; it captures the TX BRAM read data and shifts out LSB first.
REQ-010 SHALL have port serial_in  in  1  received link bit.
REQ-011 SHALL have port rx_addr  out  AW  write address to the RX BRAM.
REQ-012 SHALL have port rx_data  out  N  deserialized word.
REQ-013 SHALL have port rx_we  out  1  RX BRAM write enable.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse when the last word of a frame is written.
REQ-016 SHALL have port frame_cnt  out  16  count of completed frames; wraps at 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, FETCH, LOAD, SHIFT and STORE.
REQ-018 IDLE: start=1 -> FETCH, with word index idx cleared to 0.
REQ-019 FETCH: tx_addr=idx for one cycle to cover BRAM read latency; next state LOAD.
REQ-020 LOAD: tx_load=1 for exactly one cycle; bit counter cleared to 0; next state SHIFT.
REQ-021 SHIFT: each cycle rx_data <= {serial_in, rx_data[N-1:1]} and the bit counter increments; after N cycles (counter reaches N-1) next state STORE.
REQ-022 STORE: rx_we=1 and rx_addr=idx for exactly one cycle. If idx==DEPTH-1: pulse done, increment frame_cnt, go to IDLE. Otherwise increment idx and go to FETCH.
REQ-023 Per-word cost SHALL be exactly N+3 cycles (1 FETCH, 1 LOAD, N SHIFT, 1 STORE), with no idle cycle between words.
REQ-024 tx_addr SHALL hold idx in every state; rx_addr SHALL equal idx whenever rx_we=1.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort SHALL have priority over all transitions: next state IDLE, no rx_we, no done, frame_cnt unchanged. Any partial word in progress SHALL be discarded.
REQ-027 start and abort asserted together in IDLE: SHALL remain in IDLE.
REQ-028 idx SHALL never exceed DEPTH-1. The bit counter SHALL be ceil(log2(N+1)) bits wide.
REQ-029 rx_data SHALL hold its value outside SHIFT.

Reset
REQ-030 rst=1 SHALL asynchronously force: state IDLE, idx 0, bit counter 0, tx_addr 0, rx_addr 0, rx_data 0, tx_load 0, rx_we 0, busy 0, done 0, frame_cnt 0.
REQ-031 rst asserted mid-frame SHALL leave no rx_we or done pulse after deassertion; the first cycle after release SHALL be IDLE.

Configuration
REQ-032 Macro LINK_FRAME_LOOP_EN defined: on reaching STORE with idx==DEPTH-1, SHALL pulse done, increment frame_cnt, clear idx, and go directly to FETCH. Frames repeat until abort.
REQ-033 LINK_FRAME_LOOP_EN undefined: single-frame behaviour per REQ-022. No loop logic SHALL be synthesized.

Verification
REQ-034 Reset, then start pulse with a loopback serializer and TX BRAM = 0x00..0x09 -> RX BRAM words 0..9 = 0x00..0x09; done at cycle 10*11 after FETCH entry; frame_cnt=1.
REQ-035 Word 0xA5 at address 0 -> serial_in sequence 1,0,1,0,0,1,0,1; rx_data=0xA5 when rx_we=1 with rx_addr=0.
REQ-036 abort asserted in the 4th SHIFT cycle of word 3 -> IDLE next cycle; RX words 3..9 unwritten; done=0; frame_cnt=0.
REQ-037 start re-pulsed while busy -> no restart; idx sequence stays monotonic 0..9.
REQ-038 rst pulse during STORE of word 5 -> all outputs 0 immediately; a later start rewrites from address 0.
REQ-039 With LINK_FRAME_LOOP_EN defined, run 3 frames then abort -> frame_cnt=3; idx wraps 9->0 with FETCH directly after STORE.
